// File: rtl/rs_pkg.sv
// rs_pkg: shared definitions for the age-ordered ALU reservation station.
//   - default widths for the RoB tag, datapath and ALU op fields
//   - op-class encodings shared with the ALU decoder
//   - entry record layout at the default widths (used by the ALU-side views)
package rs_pkg;

    localparam int unsigned RS_ROB_BITS = 4;
    localparam int unsigned RS_XLEN     = 32;
    localparam int unsigned RS_OP_BITS  = 6;
    localparam int unsigned RS_DEPTH    = 8;
    localparam int unsigned RS_AGE_BITS = $clog2(RS_DEPTH);

    // Op classes occupy the top bits of the ALU op field.
    typedef enum logic [2:0] {
        OpClsU = 3'd0,
        OpClsI = 3'd1,
        OpClsB = 3'd2,
        OpClsR = 3'd3,
        OpClsJ = 3'd4
    } op_class_e;

    typedef struct packed {
        logic                   valid;
        logic [RS_OP_BITS-1:0]  op;
        logic [RS_XLEN-1:0]     vj;
        logic [RS_XLEN-1:0]     vk;
        logic [RS_ROB_BITS-1:0] tj;
        logic [RS_ROB_BITS-1:0] tk;
        logic                   rj;
        logic                   rk;
        logic [RS_XLEN-1:0]     imm;
        logic [RS_ROB_BITS-1:0] dest;
        logic [RS_AGE_BITS-1:0] age;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// rs_oldest_select: DEPTH-input max-age reduction tree.
//   cand  - per-entry candidate flags
//   ages  - per-entry ages
//   idx   - index of the oldest candidate (lower index wins equal ages)
//   found - at least one candidate present
module rs_oldest_select
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AGE_BITS = 3
) (
    input  logic [DEPTH-1:0]         cand,
    input  logic [AGE_BITS-1:0]      ages [DEPTH],
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     found
);

    localparam int unsigned IDX_BITS = $clog2(DEPTH);

    // Heap layout: leaves at DEPTH..2*DEPTH-1, root at 1, slot 0 unused.
    logic                node_found [2*DEPTH];
    logic [AGE_BITS-1:0] node_age   [2*DEPTH];
    logic [IDX_BITS-1:0] node_idx   [2*DEPTH];

    always_comb begin
        for (int n = 0; n < 2 * DEPTH; n++) begin
            node_found[n] = 1'b0;
            node_age[n]   = '0;
            node_idx[n]   = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            node_found[DEPTH+i] = cand[i];
            node_age[DEPTH+i]   = ages[i];
            node_idx[DEPTH+i]   = IDX_BITS'(i);
        end
        // Left subtree always holds lower indices, so >= gives the index tie-break.
        for (int n = DEPTH - 1; n >= 1; n--) begin
            if (node_found[2*n] &&
                (!node_found[2*n+1] || node_age[2*n] >= node_age[2*n+1])) begin
                node_found[n] = 1'b1;
                node_age[n]   = node_age[2*n];
                node_idx[n]   = node_idx[2*n];
            end else begin
                node_found[n] = node_found[2*n+1];
                node_age[n]   = node_age[2*n+1];
                node_idx[n]   = node_idx[2*n+1];
            end
        end
        found = node_found[1];
        idx   = node_idx[1];
    end

endmodule

// File: rtl/age_ordered_rs.sv
// age_ordered_rs: ALU reservation station with oldest-ready dispatch.
// Optional feature macro: RS_PARTIAL_FLUSH_EN (adds flush_partial, rob_head, flush_tag).
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global stall), flush (full clear)
//   iss_*      - one instruction per cycle from issue, iss_ready = !full
//   cdb_*      - CDB_PORTS packed broadcast ports for wakeup
//   ex_*       - dispatch to ALU over valid/ready, payload of the oldest ready entry
//   count/full - occupancy
module age_ordered_rs
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ROB_BITS  = RS_ROB_BITS,
    parameter int unsigned XLEN      = RS_XLEN,
    parameter int unsigned CDB_PORTS = 2,
    parameter int unsigned OP_BITS   = RS_OP_BITS
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush,
`ifdef RS_PARTIAL_FLUSH_EN
    input  logic                          flush_partial,
    input  logic [ROB_BITS-1:0]           rob_head,
    input  logic [ROB_BITS-1:0]           flush_tag,
`endif
    input  logic                          iss_valid,
    output logic                          iss_ready,
    input  logic [OP_BITS-1:0]            iss_op,
    input  logic [XLEN-1:0]               iss_imm,
    input  logic [ROB_BITS-1:0]           iss_dest,
    input  logic                          iss_j_rdy,
    input  logic                          iss_k_rdy,
    input  logic [ROB_BITS-1:0]           iss_j_tag,
    input  logic [ROB_BITS-1:0]           iss_k_tag,
    input  logic [XLEN-1:0]               iss_j_val,
    input  logic [XLEN-1:0]               iss_k_val,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_BITS-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]     cdb_val,
    output logic                          ex_valid,
    input  logic                          ex_ready,
    output logic [OP_BITS-1:0]            ex_op,
    output logic [XLEN-1:0]               ex_vj,
    output logic [XLEN-1:0]               ex_vk,
    output logic [XLEN-1:0]               ex_imm,
    output logic [ROB_BITS-1:0]           ex_dest,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full
);

    localparam int unsigned IDX_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;
    localparam logic [IDX_BITS-1:0] AGE_MAX = IDX_BITS'(DEPTH - 1);

    // Entry storage
    logic                valid_q [DEPTH], valid_d [DEPTH];
    logic                rj_q    [DEPTH], rj_d    [DEPTH];
    logic                rk_q    [DEPTH], rk_d    [DEPTH];
    logic [OP_BITS-1:0]  op_q    [DEPTH], op_d    [DEPTH];
    logic [XLEN-1:0]     vj_q    [DEPTH], vj_d    [DEPTH];
    logic [XLEN-1:0]     vk_q    [DEPTH], vk_d    [DEPTH];
    logic [XLEN-1:0]     imm_q   [DEPTH], imm_d   [DEPTH];
    logic [ROB_BITS-1:0] tj_q    [DEPTH], tj_d    [DEPTH];
    logic [ROB_BITS-1:0] tk_q    [DEPTH], tk_d    [DEPTH];
    logic [ROB_BITS-1:0] dest_q  [DEPTH], dest_d  [DEPTH];
    logic [IDX_BITS-1:0] age_q   [DEPTH], age_d   [DEPTH];

    // Unpacked broadcast ports
    logic [ROB_BITS-1:0] bc_tag [CDB_PORTS];
    logic [XLEN-1:0]     bc_val [CDB_PORTS];

    always_comb begin
        for (int p = 0; p < CDB_PORTS; p++) begin
            bc_tag[p] = cdb_tag[p*ROB_BITS +: ROB_BITS];
            bc_val[p] = cdb_val[p*XLEN +: XLEN];
        end
    end

    // Oldest-ready selection
    logic [DEPTH-1:0]    cand;
    logic [IDX_BITS-1:0] sel_idx;
    logic                sel_found;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = valid_q[i] && rj_q[i] && rk_q[i];
        end
    end

    rs_oldest_select #(
        .DEPTH    (DEPTH),
        .AGE_BITS (IDX_BITS)
    ) u_select (
        .cand  (cand),
        .ages  (age_q),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Occupancy and lowest free slot, both from pre-edge state
    logic [IDX_BITS-1:0] free_idx;

    always_comb begin
        count    = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            count = count + CNT_BITS'(valid_q[i]);
            if (!valid_q[i]) free_idx = IDX_BITS'(i);
        end
    end

    assign full      = (count == CNT_BITS'(DEPTH));
    assign iss_ready = !full;

    // Operand capture at issue; descending loop leaves the lowest matching port in place.
    logic [XLEN-1:0] cap_jv, cap_kv;
    logic            cap_jr, cap_kr;

    always_comb begin
        cap_jv = iss_j_val;
        cap_jr = iss_j_rdy;
        cap_kv = iss_k_val;
        cap_kr = iss_k_rdy;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (!iss_j_rdy && cdb_valid[p] && bc_tag[p] == iss_j_tag) begin
                cap_jv = bc_val[p];
                cap_jr = 1'b1;
            end
            if (!iss_k_rdy && cdb_valid[p] && bc_tag[p] == iss_k_tag) begin
                cap_kv = bc_val[p];
                cap_kr = 1'b1;
            end
        end
    end

`ifdef RS_PARTIAL_FLUSH_EN
    // Distance from the RoB head decides youngness across tag wrap-around.
    function automatic logic is_younger(input logic [ROB_BITS-1:0] dest,
                                        input logic [ROB_BITS-1:0] head,
                                        input logic [ROB_BITS-1:0] tag);
        logic [ROB_BITS-1:0] dist_dest;
        logic [ROB_BITS-1:0] dist_tag;
        dist_dest = dest - head;
        dist_tag  = tag - head;
        return dist_dest > dist_tag;
    endfunction
`endif

    logic iss_accept;
    logic dispatch;

    always_comb begin
        iss_accept = iss_valid && !full;
`ifdef RS_PARTIAL_FLUSH_EN
        // An instruction being squashed this cycle must not enter.
        if (flush_partial && is_younger(iss_dest, rob_head, flush_tag)) iss_accept = 1'b0;
`endif
    end

    assign dispatch = sel_found && ex_ready;

    // Next-state
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i];
            rj_d[i]    = rj_q[i];
            rk_d[i]    = rk_q[i];
            op_d[i]    = op_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            imm_d[i]   = imm_q[i];
            tj_d[i]    = tj_q[i];
            tk_d[i]    = tk_q[i];
            dest_d[i]  = dest_q[i];
            age_d[i]   = age_q[i];
        end

        if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_d[i] = 1'b0;
                    age_d[i]   = '0;
                end
            end else begin
                // Wakeup
                for (int i = 0; i < DEPTH; i++) begin
                    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                        if (valid_q[i] && !rj_q[i] && cdb_valid[p] && bc_tag[p] == tj_q[i]) begin
                            vj_d[i] = bc_val[p];
                            rj_d[i] = 1'b1;
                        end
                        if (valid_q[i] && !rk_q[i] && cdb_valid[p] && bc_tag[p] == tk_q[i]) begin
                            vk_d[i] = bc_val[p];
                            rk_d[i] = 1'b1;
                        end
                    end
                end

                if (dispatch) valid_d[sel_idx] = 1'b0;

                if (iss_accept) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (valid_q[i] && age_q[i] != AGE_MAX) age_d[i] = age_q[i] + IDX_BITS'(1);
                    end
                    valid_d[free_idx] = 1'b1;
                    op_d[free_idx]    = iss_op;
                    imm_d[free_idx]   = iss_imm;
                    dest_d[free_idx]  = iss_dest;
                    tj_d[free_idx]    = iss_j_tag;
                    tk_d[free_idx]    = iss_k_tag;
                    vj_d[free_idx]    = cap_jv;
                    vk_d[free_idx]    = cap_kv;
                    rj_d[free_idx]    = cap_jr;
                    rk_d[free_idx]    = cap_kr;
                    age_d[free_idx]   = '0;
                end

`ifdef RS_PARTIAL_FLUSH_EN
                if (flush_partial) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (valid_q[i] && is_younger(dest_q[i], rob_head, flush_tag)) begin
                            valid_d[i] = 1'b0;
                        end
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                rj_q[i]    <= 1'b0;
                rk_q[i]    <= 1'b0;
                op_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                imm_q[i]   <= '0;
                tj_q[i]    <= '0;
                tk_q[i]    <= '0;
                dest_q[i]  <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
                rj_q[i]    <= rj_d[i];
                rk_q[i]    <= rk_d[i];
                op_q[i]    <= op_d[i];
                vj_q[i]    <= vj_d[i];
                vk_q[i]    <= vk_d[i];
                imm_q[i]   <= imm_d[i];
                tj_q[i]    <= tj_d[i];
                tk_q[i]    <= tk_d[i];
                dest_q[i]  <= dest_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

    // Payload is zero whenever nothing is presented.
    assign ex_valid = sel_found;
    assign ex_op    = sel_found ? op_q[sel_idx]   : '0;
    assign ex_vj    = sel_found ? vj_q[sel_idx]   : '0;
    assign ex_vk    = sel_found ? vk_q[sel_idx]   : '0;
    assign ex_imm   = sel_found ? imm_q[sel_idx]  : '0;
    assign ex_dest  = sel_found ? dest_q[sel_idx] : '0;

endmodule

// File: tb/tb_age_ordered_rs.sv
// tb_age_ordered_rs: directed scenarios plus randomized traffic against a slot-level
// reference model of the reservation station.
module tb_age_ordered_rs;

    localparam int DEPTH = 8;
    localparam int ROBW  = 4;
    localparam int XLEN  = 32;
    localparam int PORTS = 2;
    localparam int OPW   = 6;

    logic              clk = 1'b0;
    logic              rst_in, rdy_in, flush;
    logic              flush_partial;
    logic [ROBW-1:0]   rob_head, flush_tag;
    logic              iss_valid, iss_ready;
    logic [OPW-1:0]    iss_op;
    logic [XLEN-1:0]   iss_imm;
    logic [ROBW-1:0]   iss_dest;
    logic              iss_j_rdy, iss_k_rdy;
    logic [ROBW-1:0]   iss_j_tag, iss_k_tag;
    logic [XLEN-1:0]   iss_j_val, iss_k_val;
    logic [PORTS-1:0]  cdb_valid;
    logic [PORTS*ROBW-1:0] cdb_tag;
    logic [PORTS*XLEN-1:0] cdb_val;
    logic              ex_valid, ex_ready;
    logic [OPW-1:0]    ex_op;
    logic [XLEN-1:0]   ex_vj, ex_vk, ex_imm;
    logic [ROBW-1:0]   ex_dest;
    logic [3:0]        count;
    logic              full;

    always #5 clk = ~clk;

    age_ordered_rs #(
        .DEPTH(DEPTH), .ROB_BITS(ROBW), .XLEN(XLEN), .CDB_PORTS(PORTS), .OP_BITS(OPW)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
`ifdef RS_PARTIAL_FLUSH_EN
        .flush_partial(flush_partial), .rob_head(rob_head), .flush_tag(flush_tag),
`endif
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_imm(iss_imm),
        .iss_dest(iss_dest), .iss_j_rdy(iss_j_rdy), .iss_k_rdy(iss_k_rdy),
        .iss_j_tag(iss_j_tag), .iss_k_tag(iss_k_tag), .iss_j_val(iss_j_val),
        .iss_k_val(iss_k_val), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_vj(ex_vj), .ex_vk(ex_vk),
        .ex_imm(ex_imm), .ex_dest(ex_dest), .count(count), .full(full)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one record per slot
    bit          m_valid [DEPTH];
    bit          m_rj [DEPTH], m_rk [DEPTH];
    logic [5:0]  m_op [DEPTH];
    logic [31:0] m_vj [DEPTH], m_vk [DEPTH], m_imm [DEPTH];
    logic [3:0]  m_tj [DEPTH], m_tk [DEPTH], m_dest [DEPTH];
    int          m_age [DEPTH];

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_age[i]   = 0;
        end
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += m_valid[i];
        return c;
    endfunction

    function automatic int m_winner();
        int best = -1;
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_rj[i] && m_rk[i] && (best < 0 || m_age[i] > m_age[best]))
                best = i;
        return best;
    endfunction

    function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] val);
        for (int p = 0; p < PORTS; p++)
            if (cdb_valid[p] && cdb_tag[p*ROBW +: ROBW] == tag) begin
                val = cdb_val[p*XLEN +: XLEN];
                return 1;
            end
        val = '0;
        return 0;
    endfunction

    function automatic bit younger(input logic [3:0] d);
        int dd = ((int'(d) - int'(rob_head)) % 16 + 16) % 16;
        int dt = ((int'(flush_tag) - int'(rob_head)) % 16 + 16) % 16;
        return dd > dt;
    endfunction

    function automatic void model_step();
        int w, free;
        bit acc;
        logic [31:0] v;
        if (!rdy_in) return;
        if (flush) begin
            m_reset();
            return;
        end
        w    = m_winner();
        free = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) free = i;
        acc = iss_valid && (m_count() < DEPTH);
`ifdef RS_PARTIAL_FLUSH_EN
        if (flush_partial && younger(iss_dest)) acc = 0;
        if (flush_partial)
            for (int i = 0; i < DEPTH; i++) if (m_valid[i] && younger(m_dest[i])) m_valid[i] = 0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && !m_rj[i] && cdb_hit(m_tj[i], v)) begin m_vj[i] = v; m_rj[i] = 1; end
            if (m_valid[i] && !m_rk[i] && cdb_hit(m_tk[i], v)) begin m_vk[i] = v; m_rk[i] = 1; end
        end
        if (w >= 0 && ex_ready) m_valid[w] = 0;
        if (acc) begin
            for (int i = 0; i < DEPTH; i++)
                if (m_valid[i]) m_age[i] = (m_age[i] + 1 > DEPTH - 1) ? DEPTH - 1 : m_age[i] + 1;
            m_valid[free] = 1;
            m_age[free]   = 0;
            m_op[free]    = iss_op;
            m_imm[free]   = iss_imm;
            m_dest[free]  = iss_dest;
            m_tj[free]    = iss_j_tag;
            m_tk[free]    = iss_k_tag;
            m_rj[free]    = iss_j_rdy || cdb_hit(iss_j_tag, v);
            m_vj[free]    = iss_j_rdy ? iss_j_val : (m_rj[free] ? v : iss_j_val);
            m_rk[free]    = iss_k_rdy || cdb_hit(iss_k_tag, v);
            m_vk[free]    = iss_k_rdy ? iss_k_val : (m_rk[free] ? v : iss_k_val);
        end
    endfunction

    task automatic check_outputs();
        int w = m_winner();
        int c = m_count();
        check_eq("ex_valid", ex_valid, w >= 0);
        if (w >= 0) begin
            check_eq("ex_dest", ex_dest, m_dest[w]);
            check_eq("ex_op", ex_op, m_op[w]);
            check_eq("ex_vj", ex_vj, m_vj[w]);
            check_eq("ex_vk", ex_vk, m_vk[w]);
            check_eq("ex_imm", ex_imm, m_imm[w]);
        end
        check_eq("count", count, c);
        check_eq("full", full, c == DEPTH);
        check_eq("iss_ready", iss_ready, c != DEPTH);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rdy_in = 1; flush = 0; flush_partial = 0; rob_head = '0; flush_tag = '0;
        iss_valid = 0; iss_op = '0; iss_imm = '0; iss_dest = '0;
        iss_j_rdy = 0; iss_k_rdy = 0; iss_j_tag = '0; iss_k_tag = '0;
        iss_j_val = '0; iss_k_val = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0; ex_ready = 0;
    endtask

    task automatic drive_issue(input logic [3:0] dest, input bit jr, input logic [3:0] jt);
        iss_valid = 1;
        iss_dest  = dest;
        iss_op    = 6'($urandom);
        iss_imm   = $urandom;
        iss_j_rdy = jr;
        iss_j_tag = jt;
        iss_j_val = $urandom;
        iss_k_rdy = 1;
        iss_k_tag = 4'($urandom);
        iss_k_val = $urandom;
    endtask

    task automatic rand_inputs();
        rdy_in    = ($urandom_range(0, 9) != 0);
        flush     = rdy_in && ($urandom_range(0, 63) == 0);
        iss_valid = ($urandom_range(0, 9) < 7);
        iss_op    = 6'($urandom);
        iss_imm   = $urandom;
        iss_dest  = 4'($urandom);
        iss_j_rdy = $urandom_range(0, 1);
        iss_k_rdy = $urandom_range(0, 1);
        iss_j_tag = 4'($urandom);
        iss_k_tag = 4'($urandom);
        iss_j_val = $urandom;
        iss_k_val = $urandom;
        cdb_valid = 2'($urandom);
        cdb_tag   = 8'($urandom);
        cdb_val   = {$urandom, $urandom};
        ex_ready  = ($urandom_range(0, 9) < 6);
    endtask

    initial begin
        set_idle();
        rst_in = 0;
        m_reset();
        #12;
        check_eq("rst_ex_valid", ex_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_iss_ready", iss_ready, 1);
        check_eq("rst_ex_dest", ex_dest, 0);
        check_eq("rst_ex_vj", ex_vj, 0);
        @(negedge clk) rst_in = 1;
        @(posedge clk) #1;

        // Three ready entries dispatch in issue order
        for (int d = 1; d <= 3; d++) begin
            drive_issue(4'(d), 1, 0);
            cycle();
        end
        set_idle();
        ex_ready = 1;
        for (int d = 1; d <= 3; d++) begin
            check_eq("order_dest", ex_dest, d);
            check_eq("order_count", count, 4 - d);
            cycle();
        end
        check_eq("order_empty", count, 0);

        // Same-cycle issue bypass from CDB port 1
        set_idle();
        drive_issue(4'd5, 0, 4'd7);
        cdb_valid = 2'b10;
        cdb_tag   = {4'd7, 4'd0};
        cdb_val   = {32'hDEADBEEF, 32'h0};
        cycle();
        set_idle();
        check_eq("bypass_valid", ex_valid, 1);
        check_eq("bypass_dest", ex_dest, 5);
        check_eq("bypass_vj", ex_vj, 32'hDEADBEEF);
        ex_ready = 1;
        cycle();

        // Fill, attempt overwrite, then dispatch+issue at full and below full
        set_idle();
        for (int i = 0; i < DEPTH; i++) begin
            drive_issue(4'(i + 1), 1, 0);
            cycle();
        end
        check_eq("fill_full", full, 1);
        check_eq("fill_iss_ready", iss_ready, 0);
        drive_issue(4'd9, 1, 0);
        cycle();
        check_eq("fill_count", count, 8);
        check_eq("fill_oldest", ex_dest, 1);
        ex_ready = 1;
        cycle();
        check_eq("full_disp_count", count, 7);
        drive_issue(4'd10, 1, 0);
        ex_ready = 1;
        cycle();
        check_eq("disp_iss_count", count, 7);
        set_idle();
        ex_ready = 1;
        for (int i = 0; i < DEPTH; i++) cycle();
        check_eq("drain_count", count, 0);

        // Older waiter overtakes younger presented entry once woken
        set_idle();
        drive_issue(4'd10, 0, 4'd4);
        cycle();
        drive_issue(4'd11, 1, 0);
        cycle();
        set_idle();
        check_eq("wait_young", ex_dest, 11);
        cdb_valid = 2'b01;
        cdb_tag   = {4'd0, 4'd4};
        cdb_val   = {32'h0, 32'h00001234};
        cycle();
        set_idle();
        check_eq("woken_old", ex_dest, 10);
        check_eq("woken_vj", ex_vj, 32'h00001234);
        ex_ready = 1;
        cycle();
        check_eq("after_hs_dest", ex_dest, 11);
        check_eq("after_hs_count", count, 1);

        // Flush discards same-cycle issue and dispatch
        drive_issue(4'd12, 1, 0);
        ex_ready = 1;
        flush    = 1;
        check_eq("flush_ex_valid", ex_valid, 1);
        cycle();
        set_idle();
        check_eq("flush_count", count, 0);
        check_eq("flush_ex_valid_after", ex_valid, 0);

        // Asynchronous reset mid-cycle with four entries
        for (int i = 0; i < 4; i++) begin
            drive_issue(4'(i), 1, 0);
            cycle();
        end
        set_idle();
        #2;
        rst_in = 0;
        #1;
        check_eq("async_ex_valid", ex_valid, 0);
        check_eq("async_count", count, 0);
        m_reset();
        @(negedge clk) rst_in = 1;
        @(posedge clk) #1;

`ifdef RS_PARTIAL_FLUSH_EN
        set_idle();
        rob_head = 4'd14;
        drive_issue(4'd15, 1, 0);
        cycle();
        drive_issue(4'd0, 1, 0);
        cycle();
        drive_issue(4'd2, 1, 0);
        cycle();
        set_idle();
        rob_head      = 4'd14;
        flush_tag     = 4'd0;
        flush_partial = 1;
        cycle();
        set_idle();
        check_eq("pflush_count", count, 2);
        check_eq("pflush_oldest", ex_dest, 15);
        flush = 1;
        cycle();
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
